// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared widths and encodings
// for the fetch-to-decode instruction buffer.
package fetch_queue_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned FQ_DEPTH = 4;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  function automatic int unsigned occ_width(
    input int unsigned depth
  );
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// fetch_queue_mem: entry storage, one write port
// and one asynchronous read port, no reset.
module fetch_queue_mem #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction/PC buffer
// between fetch and decode, emptied on flush.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned INST_WIDTH = INST_W,
  parameter int unsigned PC_WIDTH   = PC_W,
  parameter int unsigned DEPTH      = FQ_DEPTH,
  parameter logic [INST_WIDTH-1:0] NOP_INST =
    INST_WIDTH'(NOP_WORD)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INST_WIDTH-1:0] in_inst,
  input  logic [PC_WIDTH-1:0]   in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INST_WIDTH-1:0] out_inst,
  output logic [PC_WIDTH-1:0]   out_pc,
  input  logic                  flush,
  output logic [occ_width(DEPTH)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = occ_width(DEPTH);
  localparam int unsigned EW = INST_WIDTH + PC_WIDTH;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [EW-1:0] rdata;

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);

  // flush wins over both handshakes
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({in_inst, in_pc}),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign out_inst = out_valid
    ? rdata[EW-1:PC_WIDTH] : NOP_INST;
  assign out_pc = out_valid
    ? rdata[PC_WIDTH-1:0] : '0;

endmodule
